// File: rtl/stack_cpu_p.sv
// Parametrised 16-bit-encoded stack-machine core.
// Sequences each instruction through EXEC -> (MEM) -> UPDATE -> DELAY, tracks
// operand stack depth with sticky overflow/underflow faulting, talks to data
// memory through a ready-handshaked port and stops in HALT on insn 0xffff.
module stack_cpu_p #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 16,
    parameter int PC_W    = 10,
    parameter int ADDR_W  = 8,
    parameter int CLK_DIV = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [15:0]                  insn,
    output logic [PC_W-1:0]              pc,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_rd,
    output logic                         mem_wr,
    input  logic                         mem_ready,
    input  logic [DATA_W-1:0]            rd_data,
    output logic [DATA_W-1:0]            wr_data,
    output logic [DATA_W-1:0]            stack_top,
    output logic [$clog2(DEPTH+1)-1:0]   stack_depth,
    output logic                         halted,
    output logic                         fault
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [7:0] OP_PUSH = 8'h00;
    localparam logic [7:0] OP_POP  = 8'h01;
    localparam logic [7:0] OP_DUP  = 8'h02;
    localparam logic [7:0] OP_LD   = 8'h08;
    localparam logic [7:0] OP_ST   = 8'h0c;
    localparam logic [7:0] OP_STA  = 8'h0d;
    localparam logic [7:0] OP_STD  = 8'h0e;
    localparam logic [7:0] OP_JMP  = 8'h10;
    localparam logic [7:0] OP_JZ   = 8'h11;
    localparam logic [7:0] OP_ALU  = 8'h20;

    typedef enum logic [2:0] {
        S_EXEC, S_MEM, S_UPDATE, S_DELAY, S_HALT, S_FAULT
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   stack [DEPTH];
    logic [DATA_W-1:0]   stk_nxt [DEPTH];
    logic [15:0]         insn_q;
    logic [DATA_W-1:0]   rd_q;
    logic [CW-1:0]       div_cnt;

    // EXEC decode
    logic [1:0]          need;
    logic                grow, chk_en, is_mem, is_ld, exec_fault;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdat_d;

    // UPDATE results
    logic                do_push, do_pop, top_ovr;
    logic [DATA_W-1:0]   push_val, top_val;
    logic [PC_W-1:0]     pc_nxt, off;
    logic [DW-1:0]       dep_nxt;

    function automatic logic [DATA_W-1:0] alu_fn(input logic [7:0] fn,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        case (fn)
            8'h00:   r = a;
            8'h01:   r = b;
            8'h02:   r = a + b;
            8'h03:   r = a - b;
            8'h04:   r = a * b;
            8'h05:   r = a | (b << 8);
            8'h08:   r = {{(DATA_W-1){1'b0}}, (a < b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign stack_top = stack[0];

    // Decode the live instruction: stack requirement, growth, memory access setup
    always_comb begin
        need   = 2'd0;
        grow   = 1'b0;
        chk_en = 1'b1;
        is_mem = 1'b0;
        is_ld  = 1'b0;
        addr_d = ADDR_W'(insn[7:0]);
        wdat_d = stack[0];
        case (insn[15:8])
            OP_PUSH: grow = 1'b1;
            OP_POP:  need = 2'd1;
            OP_DUP:  begin need = insn[0] ? 2'd2 : 2'd1; grow = 1'b1; end
            OP_LD:   begin grow = 1'b1; is_mem = 1'b1; is_ld = 1'b1; end
            OP_ST:   begin need = 2'd1; is_mem = 1'b1; end
            OP_STA, OP_STD: begin
                need   = 2'd2;
                is_mem = 1'b1;
                addr_d = ADDR_W'(stack[0]);
                wdat_d = stack[1];
            end
            OP_JMP:  need = 2'd0;
            OP_JZ:   need = 2'd1;
            OP_ALU:  need = 2'd2;
            default: chk_en = 1'b0;
        endcase
        exec_fault = chk_en && ((DW'(need) > stack_depth) ||
                                (grow && stack_depth == DW'(DEPTH)));
    end

    // Next stack contents, depth and pc for the latched instruction
    always_comb begin
        do_push  = 1'b0;
        do_pop   = 1'b0;
        top_ovr  = 1'b0;
        push_val = rd_q;
        top_val  = stack[0];
        off      = PC_W'($signed(insn_q[7:0]));
        pc_nxt   = pc + PC_W'(1);
        case (insn_q[15:8])
            OP_PUSH: begin do_push = 1'b1; push_val = DATA_W'(insn_q[7:0]); end
            OP_POP:  do_pop = 1'b1;
            OP_DUP:  begin do_push = 1'b1; push_val = insn_q[0] ? stack[1] : stack[0]; end
            OP_LD:   begin do_push = 1'b1; push_val = rd_q; end
            OP_ST, OP_STD: do_pop = 1'b1;
            OP_STA:  begin do_pop = 1'b1; top_ovr = 1'b1; top_val = stack[0]; end
            OP_JMP:  pc_nxt = pc + off;
            OP_JZ: begin
                do_pop = 1'b1;
                if (stack[0] == '0) pc_nxt = pc + off;
            end
            OP_ALU: begin
                do_pop  = 1'b1;
                top_ovr = 1'b1;
                top_val = alu_fn(insn_q[7:0], stack[0], stack[1]);
            end
            default: do_pop = 1'b0;
        endcase

        for (int i = 0; i < DEPTH; i++) stk_nxt[i] = stack[i];
        dep_nxt = stack_depth;
        if (do_push) begin
            stk_nxt[0] = push_val;
            for (int i = 1; i < DEPTH; i++) stk_nxt[i] = stack[i-1];
            dep_nxt = stack_depth + DW'(1);
        end else if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) stk_nxt[i] = stack[i+1];
            stk_nxt[DEPTH-1] = '0;
            if (top_ovr) stk_nxt[0] = top_val;
            dep_nxt = stack_depth - DW'(1);
        end
    end

    // Instruction sequencer with registered memory strobes and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_EXEC;
            pc          <= '0;
            stack_depth <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            wr_data     <= '0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            div_cnt     <= '0;
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else begin
            case (state)
                S_EXEC: begin
                    if (insn == 16'hffff) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (exec_fault) begin
                        state <= S_FAULT;
                        fault <= 1'b1;
                    end else begin
                        insn_q <= insn;
                        if (is_mem) begin
                            mem_rd   <= is_ld;
                            mem_wr   <= !is_ld;
                            mem_addr <= addr_d;
                            if (!is_ld) wr_data <= wdat_d;
                            state <= S_MEM;
                        end else begin
                            state <= S_UPDATE;
                        end
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        rd_q   <= rd_data;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        state  <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    stack       <= stk_nxt;
                    stack_depth <= dep_nxt;
                    pc          <= pc_nxt;
                    div_cnt     <= '0;
                    state       <= S_DELAY;
                end
                S_DELAY: begin
                    if (div_cnt == CW'(CLK_DIV - 1)) state <= S_EXEC;
                    else div_cnt <= div_cnt + CW'(1);
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: doc/stack_cpu_p.md
Name: stack_cpu_p

Overview:
Parametrised successor to the 16-bit stack-machine core. It keeps the same 16-bit instruction encoding and adds four things: configurable data width, stack depth and address widths; a tracked stack depth with overflow/underflow fault detection; a ready-handshaked memory port; and an explicit HALT state. It sits between instruction ROM (indexed by pc) and the data memory/UART bus.

Parameters:
DATA_W, 16, stack entry / memory data width (>=8)
DEPTH, 16, operand stack entries (>=2)
PC_W, 10, program counter width
ADDR_W, 8, data memory address width (>=8)
CLK_DIV, 1, cycles spent in DELAY per instruction (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
insn  in  16  instruction at pc (combinational ROM)
pc  out  PC_W  program counter
mem_addr  out  ADDR_W  data memory address
mem_rd  out  1  read strobe, held until mem_ready
mem_wr  out  1  write strobe, held until mem_ready
mem_ready  in  1  memory completes access this cycle
rd_data  in  DATA_W  read data, valid when mem_ready
wr_data  out  DATA_W  write data
stack_top  out  DATA_W  stack[0]
stack_depth  out  $clog2(DEPTH+1)  valid entries
halted  out  1  0xffff reached
fault  out  1  stack overflow/underflow, sticky

Behaviour:
- Reset: one clk edge with rst_n=0 sets pc=0, state=EXEC, all entries=0, stack_depth=0, mem_rd=mem_wr=0, wr_data=0, mem_addr=0, halted=fault=0. Reset mid-access drops strobes immediately.
- States: EXEC -> (MEM if access) -> UPDATE -> DELAY -> EXEC; plus HALT and FAULT, both terminal until reset.
- Latency: non-memory instruction = 2+CLK_DIV cycles. Memory instruction = 3+CLK_DIV+W cycles, where W = cycles with mem_ready=0 while in MEM.
- Opcodes (insn[15:8]); need/net are stack entries required / depth change:
  - 00 PUSH imm8 (0/+1)
  - 01 POP (1/-1)
  - 02 DUP insn[0] (1+insn[0]/+1)
  - 08 LD imm8 (0/+1)
  - 0c ST imm8: write stack[0] (1/-1)
  - 0d STA: addr=stack[0], data=stack[1]; leaves addr on top (2/-1)
  - 0e STD: as STA; leaves data on top (2/-1)
  - 10 JMP (0/0)
  - 11 JZ: tests stack[0] before popping (1/-1)
  - 20 ALU with fn=imm8 (2/-1)
  - 0xffff: HALT
  - any other opcode: NOP, pc+1
- imm8 is zero-extended to DATA_W. LD/ST address is imm8 zero-extended to ADDR_W. STA/STD address is stack[0][ADDR_W-1:0].
- ALU functions:
  - 00 stack0; 01 stack1
  - 02 add; 03 stack0-stack1; 04 multiply. All three keep the low DATA_W bits (wrap).
  - 05 stack0 | (stack1<<8), truncated
  - 08 unsigned stack0<stack1, result 1 or 0
  - any other fn: result 0
- Fault check in EXEC: fault if depth<need, or (net=+1 and depth==DEPTH). On fault go to FAULT, fault=1; stack, pc and memory are untouched. The check is skipped for NOP and HALT.
- MEM: mem_rd/mem_wr and mem_addr/wr_data are registered on the EXEC->MEM edge and held stable while mem_ready=0. On the cycle mem_ready=1, rd_data is captured, strobes clear next cycle, and the state goes to UPDATE. mem_ready outside MEM is ignored.
- UPDATE:
  - Stack shift and depth update are applied together.
  - Vacated bottom entry on pop becomes 0.
  - Entry shifted out on push at depth DEPTH cannot occur (it faults first).
  - pc: +1, or + sign-extended imm8 for JMP / JZ-taken. Wraps modulo 2^PC_W.
- HALT: entered from EXEC when insn==16'hffff. pc frozen, halted=1, no strobes.

Test Plan:
- PUSH 5, PUSH 7, ALU 02, ST 0x20, HALT with mem_ready tied 1 -> one write: mem_addr=0x20, wr_data=12; stack_depth 0; halted=1; pc=4; each non-memory instruction takes 3 cycles (CLK_DIV=1).
- LD 0x21 with mem_ready low for 4 cycles, rd_data=0xBEEF on the ready cycle -> mem_rd high exactly 5 cycles, addr stable; stack_top=0xBEEF; depth 1.
- DEPTH=4: five PUSH 1 -> fifth sets fault=1 in FAULT; depth stays 4; pc stays 4; no further pc change.
- POP with depth 0 -> fault=1; also ALU 02 with depth 1 -> fault=1 (run after reset).
- PUSH 0, JZ -2 at pc=1 -> pc=0xFFFF mod 2^PC_W (1023); depth 0. PUSH 3, JZ +5 -> pc+1; depth 0.
- DATA_W=8: PUSH 200, PUSH 100, ALU 02 -> top=44. Then assert rst_n=0 during a pending ST -> strobes low next edge, all outputs at reset values.
